// File: rtl/stepper_phase_sequencer_if.sv
// Command/status bundle between the motion control logic and the stepper
// phase sequencer.
//   master : control side; drives start/dir/half_step/step_count/stop and
//            observes coils/busy/done/steps_left/position.
//   slave  : sequencer side.
// CNT_W and POS_W must match the parameters of the sequencer instance.
interface stepper_phase_sequencer_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned POS_W = 16
);
  logic             start;
  logic             dir;
  logic             half_step;
  logic [CNT_W-1:0] step_count;
  logic             stop;
  logic [3:0]       coils;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;
  logic [POS_W-1:0] position;

  modport master (
    output start, dir, half_step, step_count, stop,
    input  coils, busy, done, steps_left, position
  );

  modport slave (
    input  start, dir, half_step, step_count, stop,
    output coils, busy, done, steps_left, position
  );
endinterface

// File: rtl/stepper_phase_sequencer.sv
// Stepper phase sequencer: synchronises the slow step clock, turns each of
// its rising edges into a one-cycle tick and walks a 4-coil unipolar motor
// through a full- or half-step phase table for a commanded move.
// Ports:
//   clk      system clock, all logic on its rising edge
//   rst_n    synchronous active-low reset
//   slow_clk asynchronous slow step clock
//   bus      slave side of stepper_phase_sequencer_if (command in, status out)
module stepper_phase_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned POS_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD        = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       slow_clk,
  stepper_phase_sequencer_if.slave   bus
);

  // A single flop is never an acceptable synchroniser.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Phase table; odd indices energise two coils (full-step positions).
  function automatic logic [3:0] phase_lut(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  logic [SYNC_N-1:0] sync_q;
  logic              prev_q;
  logic              tick_c;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              half_q, half_d;
  logic [3:0]        coils_q, coils_d;
  logic              busy_q, done_q;
  logic [2:0]        stride_c;

  // Synchroniser and rising-edge detect. Reset to 1 so a slow_clk that is
  // already high when reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], slow_clk};
      prev_q <= sync_q[SYNC_N-1];
    end
  end

  assign tick_c = sync_q[SYNC_N-1] & ~prev_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      steps_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      coils_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      coils_q <= coils_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == FINISH);
    end
  end

  assign stride_c = half_q ? 3'd1 : 3'd2;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    steps_d = steps_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    half_d  = half_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.step_count != '0) begin
            dir_d   = bus.dir;
            half_d  = bus.half_step;
            steps_d = bus.step_count;
            // Full-step runs on odd indices only; snapping is not a step.
            if (!bus.half_step) idx_d = idx_q | 3'd1;
            state_d = RUN;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RUN: begin
        // stop takes priority over a coincident tick.
        if (bus.stop) begin
          state_d = FINISH;
        end else if (tick_c) begin
          idx_d   = dir_q ? (idx_q + stride_c) : (idx_q - stride_c);
          steps_d = steps_q - CNT_W'(1);
          pos_d   = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
          if (steps_q == CNT_W'(1)) state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Coils follow the index while moving; when not moving they hold the
    // phase or de-energise depending on HOLD.
    if ((HOLD != 32'd0) || (state_d == RUN)) coils_d = phase_lut(idx_d);
    else                                     coils_d = 4'b0000;
  end

  assign bus.coils      = coils_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_left = steps_q;
  assign bus.position   = pos_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Directed bench for stepper_phase_sequencer (HOLD=1, SYNC_STAGES=2).
module tb_stepper_phase_sequencer;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned POS_W = 16;

  logic clk;
  logic rst_n;
  logic slow_clk;
  int   total;
  int   bad;
  logic [3:0] pre_coils;

  stepper_phase_sequencer_if #(.CNT_W(CNT_W), .POS_W(POS_W)) bus ();

  stepper_phase_sequencer #(
    .CNT_W(CNT_W), .POS_W(POS_W), .SYNC_STAGES(2), .HOLD(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .slow_clk(slow_clk),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise slow_clk and stop just after the edge where the coils react
  // (3 edges). Coils seen one edge earlier are kept in pre_coils. When
  // with_stop is set, stop is held during the tick cycle.
  task automatic slow_rise(input bit with_stop);
    slow_clk = 1'b1;
    clk_n(2);
    pre_coils = bus.coils;
    bus.stop = with_stop;
    clk_n(1);
    bus.stop = 1'b0;
  endtask

  task automatic slow_fall();
    clk_n(17);
    slow_clk = 1'b0;
    clk_n(20);
  endtask

  task automatic issue_start(input bit d, input bit h, input logic [CNT_W-1:0] n);
    bus.dir = d;
    bus.half_step = h;
    bus.step_count = n;
    bus.start = 1'b1;
    clk_n(1);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    slow_clk = 1'b1;
    clk_n(3);
    total++; if (bus.coils !== 4'b0000) begin bad++; $display("FAIL rst_coils: got %b want 0000", bus.coils); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    total++; if (bus.steps_left !== 16'h0000) begin bad++; $display("FAIL rst_steps: got %h want 0000", bus.steps_left); end
    total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL rst_pos: got %h want 0000", bus.position); end
    rst_n = 1'b1;
    clk_n(1);
    total++; if (bus.coils !== 4'b1000) begin bad++; $display("FAIL idle_hold_coils: got %b want 1000", bus.coils); end
    // slow_clk still high: no tick may reach the move.
    issue_start(1'b1, 1'b1, 16'd4);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL run_busy: got %b want 1", bus.busy); end
    clk_n(10);
    total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL no_tick_pos: got %h want 0000", bus.position); end
    bus.stop = 1'b1;
    clk_n(1);
    bus.stop = 1'b0;
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL stop_done: got %b want 1", bus.done); end
    total++; if (bus.steps_left !== 16'd4) begin bad++; $display("FAIL stop_steps: got %h want 0004", bus.steps_left); end
    clk_n(1);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stop_done_fall: got %b want 0", bus.done); end
    slow_clk = 1'b0;
    clk_n(5);
  endtask

  task automatic test_half_fwd();
    logic [3:0] exp_c [3];
    logic [3:0] prev_c;
    exp_c = '{4'b1100, 4'b0100, 4'b0110};
    prev_c = 4'b1000;
    issue_start(1'b1, 1'b1, 16'd3);
    total++; if (bus.steps_left !== 16'd3) begin bad++; $display("FAIL hf_steps0: got %h want 0003", bus.steps_left); end
    for (int i = 0; i < 3; i++) begin
      slow_rise(1'b0);
      total++; if (pre_coils !== prev_c) begin bad++; $display("FAIL hf_latency%0d: got %b want %b", i, pre_coils, prev_c); end
      total++; if (bus.coils !== exp_c[i]) begin bad++; $display("FAIL hf_coils%0d: got %b want %b", i, bus.coils, exp_c[i]); end
      prev_c = exp_c[i];
      if (i < 2) begin
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hf_early_done%0d: got %b want 0", i, bus.done); end
        slow_fall();
      end
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL hf_done: got %b want 1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hf_busy: got %b want 0", bus.busy); end
    total++; if (bus.position !== 16'd3) begin bad++; $display("FAIL hf_pos: got %h want 0003", bus.position); end
    total++; if (bus.steps_left !== 16'd0) begin bad++; $display("FAIL hf_steps: got %h want 0000", bus.steps_left); end
    clk_n(1);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hf_done_once: got %b want 0", bus.done); end
    slow_fall();
  endtask

  task automatic test_full_rev();
    logic [3:0] exp_c [5];
    exp_c = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001};
    rst_n = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(1);
    total++; if (bus.coils !== 4'b1000) begin bad++; $display("FAIL fr_idx0: got %b want 1000", bus.coils); end
    issue_start(1'b0, 1'b0, 16'd5);
    total++; if (bus.coils !== 4'b1100) begin bad++; $display("FAIL fr_snap: got %b want 1100", bus.coils); end
    total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL fr_snap_pos: got %h want 0000", bus.position); end
    total++; if (bus.steps_left !== 16'd5) begin bad++; $display("FAIL fr_snap_steps: got %h want 0005", bus.steps_left); end
    for (int i = 0; i < 5; i++) begin
      slow_rise(1'b0);
      total++; if (bus.coils !== exp_c[i]) begin bad++; $display("FAIL fr_coils%0d: got %b want %b", i, bus.coils, exp_c[i]); end
      if (i < 4) slow_fall();
    end
    total++; if (bus.position !== 16'hFFFB) begin bad++; $display("FAIL fr_pos: got %h want fffb", bus.position); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fr_done: got %b want 1", bus.done); end
    slow_fall();
  endtask

  task automatic test_abort();
    logic [3:0] exp_c [3];
    exp_c = '{4'b1000, 4'b1100, 4'b0100};
    issue_start(1'b1, 1'b1, 16'd10);
    for (int i = 0; i < 3; i++) begin
      slow_rise(1'b0);
      total++; if (bus.coils !== exp_c[i]) begin bad++; $display("FAIL ab_coils%0d: got %b want %b", i, bus.coils, exp_c[i]); end
      slow_fall();
    end
    slow_rise(1'b1);
    total++; if (bus.coils !== 4'b0100) begin bad++; $display("FAIL ab_frozen: got %b want 0100", bus.coils); end
    total++; if (bus.steps_left !== 16'd7) begin bad++; $display("FAIL ab_steps: got %h want 0007", bus.steps_left); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ab_done: got %b want 1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", bus.busy); end
    total++; if (bus.position !== 16'hFFFE) begin bad++; $display("FAIL ab_pos: got %h want fffe", bus.position); end
    slow_fall();
  endtask

  task automatic test_zero_count();
    issue_start(1'b1, 1'b1, 16'd0);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL zc_done: got %b want 1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zc_busy: got %b want 0", bus.busy); end
    total++; if (bus.coils !== 4'b0100) begin bad++; $display("FAIL zc_coils: got %b want 0100", bus.coils); end
    total++; if (bus.position !== 16'hFFFE) begin bad++; $display("FAIL zc_pos: got %h want fffe", bus.position); end
    total++; if (bus.steps_left !== 16'd7) begin bad++; $display("FAIL zc_steps: got %h want 0007", bus.steps_left); end
    clk_n(1);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL zc_done_fall: got %b want 0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zc_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    bus.stop = 1'b1;
    clk_n(1);
    bus.stop = 1'b0;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL idle_stop_done: got %b want 0", bus.done); end
    issue_start(1'b1, 1'b1, 16'd2);
    issue_start(1'b0, 1'b0, 16'd9);
    total++; if (bus.steps_left !== 16'd2) begin bad++; $display("FAIL bb_steps: got %h want 0002", bus.steps_left); end
    total++; if (bus.coils !== 4'b0100) begin bad++; $display("FAIL bb_no_snap: got %b want 0100", bus.coils); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bb_busy: got %b want 1", bus.busy); end
    slow_rise(1'b0);
    total++; if (bus.coils !== 4'b0110) begin bad++; $display("FAIL bb_coils0: got %b want 0110", bus.coils); end
    total++; if (bus.position !== 16'hFFFF) begin bad++; $display("FAIL bb_pos0: got %h want ffff", bus.position); end
    slow_fall();
    slow_rise(1'b0);
    total++; if (bus.coils !== 4'b0010) begin bad++; $display("FAIL bb_coils1: got %b want 0010", bus.coils); end
    total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL bb_pos1: got %h want 0000", bus.position); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL bb_done: got %b want 1", bus.done); end
    slow_fall();
  endtask

  task automatic test_reset_mid_run();
    issue_start(1'b1, 1'b1, 16'd4);
    slow_rise(1'b0);
    total++; if (bus.coils !== 4'b0011) begin bad++; $display("FAIL rm_coils: got %b want 0011", bus.coils); end
    total++; if (bus.position !== 16'd1) begin bad++; $display("FAIL rm_pos: got %h want 0001", bus.position); end
    rst_n = 1'b0;
    clk_n(1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL rm_pos_rst: got %h want 0000", bus.position); end
    total++; if (bus.coils !== 4'b0000) begin bad++; $display("FAIL rm_coils_rst: got %b want 0000", bus.coils); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
    slow_clk = 1'b0;
    clk_n(1);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_done_after: got %b want 0", bus.done); end
    clk_n(5);
    issue_start(1'b1, 1'b1, 16'd2);
    slow_rise(1'b0);
    total++; if (bus.coils !== 4'b1100) begin bad++; $display("FAIL rm2_coils0: got %b want 1100", bus.coils); end
    slow_fall();
    slow_rise(1'b0);
    total++; if (bus.coils !== 4'b0100) begin bad++; $display("FAIL rm2_coils1: got %b want 0100", bus.coils); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rm2_done: got %b want 1", bus.done); end
    total++; if (bus.position !== 16'd2) begin bad++; $display("FAIL rm2_pos: got %h want 0002", bus.position); end
    slow_fall();
  endtask

  initial begin
    total = 0;
    bad = 0;
    pre_coils = 4'b0000;
    rst_n = 1'b0;
    slow_clk = 1'b1;
    bus.start = 1'b0;
    bus.dir = 1'b0;
    bus.half_step = 1'b0;
    bus.step_count = '0;
    bus.stop = 1'b0;
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_abort();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
